// File: rtl/filter_pass_ctrl.sv
// Pass sequencer for the Sobel filter grid: tags pixels with raster coordinates and drives pass setup.
// Define FPC_BACKPRESSURE_EN to honour grid_ready; otherwise grid_ready is ignored.
module filter_pass_ctrl #(
    parameter int IMG_W     = 640,
    parameter int IMG_H     = 480,
    parameter int DRAIN_CYC = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [11:0] pix_in,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic        grid_ready,
    output logic [33:0] grid_data,
    output logic        grid_valid,
    output logic        grid_vertical,
    output logic [10:0] grid_x_dc,
    output logic [10:0] grid_y_dc,
    output logic [26:0] grid_v_coef,
    output logic [26:0] grid_h_coef,
    output logic        busy,
    output logic        pass_done,
    output logic        pass_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [10:0] X_LAST     = 11'(IMG_W - 1);
    localparam logic [10:0] Y_LAST     = 11'(IMG_H - 1);
    localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_CYC - 1);
    localparam logic [10:0] DC_NONE    = 11'h7FF;

    // Taps packed tap8..tap0, each a signed 3-bit code.
    localparam logic [26:0] V_COEF = 27'b001_000_111_010_000_110_001_000_111;
    localparam logic [26:0] H_COEF = 27'b001_010_001_000_000_000_111_110_111;

    state_t      r_state;
    logic [1:0]  r_mode;
    logic [10:0] r_x;
    logic [10:0] r_y;
    logic [3:0]  r_drain_cnt;
    logic [33:0] r_grid_data;
    logic        r_grid_valid;
    logic        r_grid_vertical;
    logic [10:0] r_grid_x_dc;
    logic [10:0] r_grid_y_dc;
    logic [26:0] r_grid_v_coef;
    logic [26:0] r_grid_h_coef;
    logic        r_busy;
    logic        r_pass_done;
    logic        r_pass_id;

    logic        w_run;
    logic        w_xfer;
    logic        w_hold;

    assign w_run = (r_state == S_RUN);

`ifdef FPC_BACKPRESSURE_EN
    assign pix_ready = w_run && (!r_grid_valid || grid_ready);
    assign w_hold    = r_grid_valid && !grid_ready;
`else
    logic w_unused_grid_ready;
    assign w_unused_grid_ready = grid_ready;
    assign pix_ready = w_run;
    assign w_hold    = 1'b0;
`endif

    assign w_xfer = pix_valid && pix_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_mode          <= 2'b00;
            r_x             <= '0;
            r_y             <= '0;
            r_drain_cnt     <= '0;
            r_grid_data     <= '0;
            r_grid_valid    <= 1'b0;
            r_grid_vertical <= 1'b0;
            r_grid_x_dc     <= DC_NONE;
            r_grid_y_dc     <= DC_NONE;
            r_grid_v_coef   <= '0;
            r_grid_h_coef   <= '0;
            r_busy          <= 1'b0;
            r_pass_done     <= 1'b0;
            r_pass_id       <= 1'b0;
        end else begin
`ifdef FPC_BACKPRESSURE_EN
            if (w_xfer) begin
                r_grid_valid <= 1'b1;
            end else if (grid_ready) begin
                r_grid_valid <= 1'b0;
            end
`else
            r_grid_valid <= w_xfer;
`endif
            if (w_xfer) begin
                r_grid_data <= {r_y, r_x, pix_in};
            end
            r_pass_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_pass_id <= 1'b0;
                    if (start) begin
                        r_mode  <= (mode == 2'b11) ? 2'b00 : mode;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_x             <= '0;
                    r_y             <= '0;
                    r_drain_cnt     <= '0;
                    r_grid_vertical <= !((r_mode == 2'b01) || ((r_mode == 2'b10) && r_pass_id));
                    r_grid_v_coef   <= V_COEF;
                    r_grid_h_coef   <= H_COEF;
                    r_grid_x_dc     <= X_LAST;
                    r_grid_y_dc     <= Y_LAST;
                    r_state         <= S_RUN;
                end
                S_RUN: begin
                    if (w_xfer) begin
                        if (r_x == X_LAST) begin
                            r_x <= '0;
                            if (r_y == Y_LAST) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_y <= r_y + 11'd1;
                            end
                        end else begin
                            r_x <= r_x + 11'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    // The flush countdown only runs once the final word has left the output register.
                    if (!w_hold) begin
                        if (r_drain_cnt == DRAIN_LAST) begin
                            r_drain_cnt <= '0;
                            r_state     <= S_DONE;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    r_pass_done     <= 1'b1;
                    r_grid_vertical <= 1'b0;
                    if ((r_mode == 2'b10) && !r_pass_id) begin
                        r_pass_id <= 1'b1;
                        r_state   <= S_LOAD;
                    end else begin
                        r_busy        <= 1'b0;
                        r_grid_x_dc   <= DC_NONE;
                        r_grid_y_dc   <= DC_NONE;
                        r_grid_v_coef <= '0;
                        r_grid_h_coef <= '0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grid_data     = r_grid_data;
    assign grid_valid    = r_grid_valid;
    assign grid_vertical = r_grid_vertical;
    assign grid_x_dc     = r_grid_x_dc;
    assign grid_y_dc     = r_grid_y_dc;
    assign grid_v_coef   = r_grid_v_coef;
    assign grid_h_coef   = r_grid_h_coef;
    assign busy          = r_busy;
    assign pass_done     = r_pass_done;
    assign pass_id       = r_pass_id;

endmodule

// File: tb/tb_filter_pass_ctrl.sv
// Directed bench for filter_pass_ctrl on a 4x2 image: frame vectors from a table plus reset,
// start-filtering and (with FPC_BACKPRESSURE_EN) grid stall sequences.
module tb_filter_pass_ctrl;

    localparam int IMG_W     = 4;
    localparam int IMG_H     = 2;
    localparam int DRAIN_CYC = 2;
    localparam int NPIX      = IMG_W * IMG_H;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [11:0] pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic        grid_ready = 1'b1;
    logic [33:0] grid_data;
    logic        grid_valid;
    logic        grid_vertical;
    logic [10:0] grid_x_dc;
    logic [10:0] grid_y_dc;
    logic [26:0] grid_v_coef;
    logic [26:0] grid_h_coef;
    logic        busy;
    logic        pass_done;
    logic        pass_id;

    filter_pass_ctrl #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .pix_in       (pix_in),
        .pix_valid    (pix_valid),
        .pix_ready    (pix_ready),
        .grid_ready   (grid_ready),
        .grid_data    (grid_data),
        .grid_valid   (grid_valid),
        .grid_vertical(grid_vertical),
        .grid_x_dc    (grid_x_dc),
        .grid_y_dc    (grid_y_dc),
        .grid_v_coef  (grid_v_coef),
        .grid_h_coef  (grid_h_coef),
        .busy         (busy),
        .pass_done    (pass_done),
        .pass_id      (pass_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        bit         toggle;
        int         passes;
        bit         vert0;
        bit         vert1;
        bit         pokeStart;
    } frameVec_t;

    frameVec_t   vecs[6];
    int          vTaps[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    int          hTaps[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};
    logic [26:0] expV;
    logic [26:0] expH;
    int          checks = 0;
    int          failures = 0;
    string       curTag = "init";

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s/%s: got %0h expected %0h", curTag, name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] expWord(input int k);
        return {11'(k / IMG_W), 11'(k % IMG_W), 12'(k)};
    endfunction

    // Runs one whole frame (one or two passes) and checks every cycle against the vector.
    task automatic applyStimulus(input frameVec_t v);
        int runCycles;
        int sent;
        int cnt;
        bit expVert;
        mode  = v.mode;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = ~v.mode;
        checkOutput("busy_load", busy, 1);
        for (int p = 0; p < v.passes; p++) begin
            expVert = (p == 0) ? v.vert0 : v.vert1;
            checkOutput("ready_load", pix_ready, 0);
            tick();
            runCycles = 0;
            sent = 0;
            while (sent < NPIX && runCycles < 64) begin
                pix_valid = v.toggle ? (runCycles % 2 == 1) : 1'b1;
                pix_in    = 12'(sent);
                checkOutput("ready_run", pix_ready, 1);
                if (runCycles == 3 && v.pokeStart) start = 1'b1;
                tick();
                start = 1'b0;
                runCycles++;
                if (pix_valid) begin
                    checkOutput("valid_xfer", grid_valid, 1);
                    checkOutput("data", grid_data, expWord(sent));
                    sent++;
                end else begin
                    checkOutput("valid_idle", grid_valid, 0);
                end
            end
            pix_valid = 1'b0;
            checkOutput("run_cycles", runCycles, v.toggle ? 2 * NPIX : NPIX);
            checkOutput("ready_drain", pix_ready, 0);
            checkOutput("vertical", grid_vertical, expVert);
            checkOutput("pass_id", pass_id, p);
            checkOutput("x_dc", grid_x_dc, IMG_W - 1);
            checkOutput("y_dc", grid_y_dc, IMG_H - 1);
            checkOutput("v_coef", grid_v_coef, expV);
            checkOutput("h_coef", grid_h_coef, expH);
            cnt = 1 + runCycles;
            while (!pass_done && cnt < 64) begin
                if (v.pokeStart && p == v.passes - 1 && cnt == 1 + runCycles + DRAIN_CYC) start = 1'b1;
                tick();
                start = 1'b0;
                cnt++;
            end
            checkOutput("pass_done_seen", pass_done, 1);
            checkOutput("pass_done_time", cnt, 2 + runCycles + DRAIN_CYC);
            checkOutput("busy_after_done", busy, (p == v.passes - 1) ? 0 : 1);
        end
        tick();
        checkOutput("pass_done_pulse", pass_done, 0);
        checkOutput("busy_idle", busy, 0);
        checkOutput("vertical_idle", grid_vertical, 0);
        checkOutput("x_dc_idle", grid_x_dc, 11'h7FF);
        checkOutput("v_coef_idle", grid_v_coef, 0);
        checkOutput("ready_idle", pix_ready, 0);
    endtask

    task automatic checkResetValues();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_valid", grid_valid, 0);
        checkOutput("rst_data", grid_data, 0);
        checkOutput("rst_ready", pix_ready, 0);
        checkOutput("rst_vertical", grid_vertical, 0);
        checkOutput("rst_x_dc", grid_x_dc, 11'h7FF);
        checkOutput("rst_y_dc", grid_y_dc, 11'h7FF);
        checkOutput("rst_coef", {grid_v_coef, grid_h_coef}, 0);
        checkOutput("rst_pass_done", pass_done, 0);
        checkOutput("rst_pass_id", pass_id, 0);
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 9; i++) begin
            expV[3*i +: 3] = 3'(vTaps[i]);
            expH[3*i +: 3] = 3'(hTaps[i]);
        end
        vecs[0] = '{mode: 2'b00, toggle: 1'b0, passes: 1, vert0: 1'b1, vert1: 1'b0, pokeStart: 1'b0};
        vecs[1] = '{mode: 2'b01, toggle: 1'b0, passes: 1, vert0: 1'b0, vert1: 1'b0, pokeStart: 1'b0};
        vecs[2] = '{mode: 2'b10, toggle: 1'b0, passes: 2, vert0: 1'b1, vert1: 1'b0, pokeStart: 1'b0};
        vecs[3] = '{mode: 2'b11, toggle: 1'b0, passes: 1, vert0: 1'b1, vert1: 1'b0, pokeStart: 1'b1};
        vecs[4] = '{mode: 2'b00, toggle: 1'b1, passes: 1, vert0: 1'b1, vert1: 1'b0, pokeStart: 1'b0};
        vecs[5] = '{mode: 2'b10, toggle: 1'b1, passes: 2, vert0: 1'b1, vert1: 1'b0, pokeStart: 1'b1};

        #1 rst = 1'b1;
        #1;
        curTag = "reset";
        checkResetValues();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            curTag = $sformatf("vec%0d", i);
            applyStimulus(vecs[i]);
        end

        // Abort mid-frame with the next pixel at x=2, y=1.
        curTag = "abort";
        mode  = 2'b00;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        pix_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pix_in = 12'(k);
            tick();
        end
        checkOutput("pre_abort_data", grid_data, expWord(5));
        #2 rst = 1'b1;
        #1;
        checkResetValues();
        pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        tick();
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (pass_done) pulses++;
            tick();
        end
        checkOutput("no_pass_done", pulses, 0);
        curTag = "restart";
        applyStimulus(vecs[0]);

`ifdef FPC_BACKPRESSURE_EN
        begin
            int sent, recv, stallA, stallB, cyc, accCyc;
            bit xfer, acc, done;
            sent = 0; recv = 0; stallA = 0; stallB = 0; cyc = 0; accCyc = -100; done = 1'b0;
            curTag = "bp";
            mode  = 2'b00;
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            while (!done && cyc < 100) begin
                pix_valid = (sent < NPIX);
                pix_in    = 12'(sent);
                if (recv == 3 && stallA < 3) begin
                    grid_ready = 1'b0;
                    stallA++;
                end else if (recv == NPIX - 1 && stallB < 3) begin
                    grid_ready = 1'b0;
                    stallB++;
                end else begin
                    grid_ready = 1'b1;
                end
                #1;
                xfer = pix_valid && pix_ready;
                acc  = grid_valid && grid_ready;
                if (grid_valid && !grid_ready) begin
                    checkOutput("stall_ready", pix_ready, 0);
                    checkOutput("stall_hold", grid_data, expWord(recv));
                end
                if (acc) begin
                    checkOutput("word", grid_data, expWord(recv));
                    recv++;
                    if (recv == NPIX) accCyc = cyc;
                end
                tick();
                cyc++;
                if (xfer) sent++;
                if (pass_done) done = 1'b1;
            end
            pix_valid  = 1'b0;
            grid_ready = 1'b1;
            checkOutput("done_seen", done, 1);
            checkOutput("recv_count", recv, NPIX);
            checkOutput("sent_count", sent, NPIX);
            checkOutput("stalls_applied", stallA + stallB, 6);
            checkOutput("drain_after_take", cyc, accCyc + DRAIN_CYC + 1);
            tick();
        end
`else
        curTag = "ready_ignored";
        grid_ready = 1'b0;
        applyStimulus(vecs[0]);
        grid_ready = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/filter_pass_ctrl.md
# filter_pass_ctrl

Sequencer that drives the Sobel filter grid for one or two passes per frame. Accepts the raw 12-bit pixel stream, tags each pixel with raster coordinates, and packs them into the 34-bit grid word. Selects vertical/horizontal pass, supplies the 3x3 coefficient set and the don't-care edge coordinates, and reports pass completion. Sits between the pixel source (capture/line buffer) and the filter grid array.

## Interface
- `IMG_W`, default 640: pixels per line, range 2..2047.
- `IMG_H`, default 480: lines per frame, range 2..2047.
- `DRAIN_CYC`, default 2: cycles waited after the last pixel for grid and adder-tree flush, range 1..15.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a frame; sampled only in IDLE.
- `mode` in 2: `00` vertical only, `01` horizontal only, `10` vertical then horizontal, `11` reserved and treated as `00`. Latched on accepted `start`.
- `pix_in` in 12: unsigned pixel.
- `pix_valid` in 1: pixel present.
- `pix_ready` out 1: controller accepts pixel.
- `grid_ready` in 1: grid can take a word. Used only with the backpressure macro.
- `grid_data` out 34: `{y[10:0], x[10:0], pix[11:0]}`.
- `grid_valid` out 1: `grid_data` valid.
- `grid_vertical` out 1: 1 during a vertical pass.
- `grid_x_dc`, `grid_y_dc` out 11: edge coordinates whose taps the grid zeroes.
- `grid_v_coef`, `grid_h_coef` out 27: nine signed 3-bit taps, tap0 in [2:0], row-major.
- `busy` out 1: high from LOAD through the final DONE.
- `pass_done` out 1: one-cycle pulse at the end of each pass.
- `pass_id` out 1: 0 for the first pass and 1 for the second pass of mode `10`.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- **IDLE**
  - `start` → LOAD; latch `mode`.
  - Set `pass_id` to 0.
- **LOAD** (1 cycle)
  - Clear x and y.
  - Set `grid_vertical` to 1 for modes 00, 10 and 11; set it to 0 for mode 01.
  - Drive coefficients: v = -1,0,1,-2,0,2,-1,0,1; h = -1,-2,-1,0,0,0,1,2,1.
  - Set `grid_x_dc` = IMG_W-1 and `grid_y_dc` = IMG_H-1.
  - Next state is RUN.
- **RUN**
  - A transfer occurs when `pix_valid && pix_ready`.
  - On each transfer, register `grid_data` = {y, x, pix_in}, assert `grid_valid` the next cycle, then advance x.
  - When x = IMG_W-1: x wraps to 0 and y increments.
  - The transfer at (IMG_W-1, IMG_H-1) → DRAIN. `pix_ready` is low from the next cycle.
- **DRAIN**
  - Count DRAIN_CYC cycles, then → DONE.
  - `grid_valid` deasserts once the last word has been taken.
- **DONE** (1 cycle)
  - Pulse `pass_done`.
  - In mode `10` with `pass_id`=0: set `pass_id` to 1, clear `grid_vertical`, → LOAD.
  - Otherwise → IDLE and drop `busy`.
- IDLE drive values: `grid_x_dc`/`grid_y_dc` = 11'h7FF, coefficients = 0, `grid_vertical` = 0.
- Reset values: state IDLE, all outputs 0 except `grid_x_dc`/`grid_y_dc` = 11'h7FF, x = y = 0.
- `rst` mid-frame aborts immediately. No `pass_done` is issued. Any partial frame is discarded.
- `start` outside IDLE is ignored. `start` on the same cycle as the DONE→IDLE transition is also ignored.
- `mode` changes after LOAD have no effect until the next accepted `start`.

## Timing
- `start` high at edge N: LOAD at N+1, RUN at N+2. `pix_ready` is first high in cycle N+2.
- Latency from pixel accept to `grid_valid`/`grid_data` is 1 cycle (registered output).
- Minimum single-pass duration, with no stalls: 2 + IMG_W·IMG_H + DRAIN_CYC + 1 cycles.
- Mode `10` inserts exactly one LOAD cycle between passes.
- Counters are 11-bit. Comparisons are against IMG_W-1 and IMG_H-1, so there is no overflow.

## Configuration
- `FPC_BACKPRESSURE_EN` defined:
  - `pix_ready` = RUN && (!`grid_valid` || `grid_ready`).
  - `grid_data`/`grid_valid` hold stable while `grid_valid && !grid_ready`.
  - DRAIN starts counting only after the last word has been taken.
- `FPC_BACKPRESSURE_EN` undefined:
  - `grid_ready` is ignored.
  - `pix_ready` = RUN.
  - `grid_valid` is the registered transfer strobe.

## Test plan
- IMG_W=4, IMG_H=2, mode 00, `pix_valid` held high, `pix_in`=k for pixel k:
  - 8 `grid_valid` cycles with `grid_data` {0,0,0} … {1,3,7}.
  - `grid_vertical`=1, `grid_x_dc`=3, `grid_y_dc`=1.
  - `pass_done` pulses 2+8+DRAIN_CYC cycles after LOAD.
- Mode 10:
  - Two passes with `pass_id` 0 then 1.
  - `grid_vertical` 1 then 0.
  - Exactly one LOAD cycle between passes.
  - `busy` drops the cycle after the second DONE.
- `pix_valid` toggling 1/0:
  - x/y advance only on transfers.
  - 16 cycles of RUN for 8 pixels.
  - Coordinates match the first test.
- Assert `rst` when x=2, y=1:
  - All outputs go to reset values asynchronously and `pass_done` never pulses.
  - A following `start` restarts at {0,0}.
- `start` pulsed during RUN, and mode 11:
  - `start` during RUN is ignored.
  - Mode 11 behaves as vertical only.
- With `FPC_BACKPRESSURE_EN`, `grid_ready` low for 3 cycles mid-frame:
  - `grid_data` holds and `pix_ready` is low.
  - No word is lost or duplicated.
  - DRAIN waits for the final acceptance.
